// File: rtl/camera_param_fetch_master.sv
// Avalon-MM read initiator: fetches NUM_WORDS camera parameter words into a shadow bank,
// then commits the whole bank to params_out in one cycle so consumers never see a torn update.
module camera_param_fetch_master #(
  parameter int unsigned NUM_WORDS   = 6,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int unsigned ADDR_STRIDE = 16,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [31:0]            m_address,
  output logic                   m_read,
  input  logic                   m_waitrequest,
  input  logic [31:0]            m_readdata,
  input  logic                   m_readdatavalid,
  output logic [32*NUM_WORDS-1:0] params_out,
  output logic                   params_valid
);

  localparam int unsigned IdxW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [IdxW-1:0] LastIdx    = IdxW'(NUM_WORDS - 1);
  localparam logic [CntW-1:0] TimeoutCnt = CntW'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StCommit} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     shadow_q [NUM_WORDS];
  logic            timed_out;

  // The timeout check wins over a response arriving in the same cycle.
  assign timed_out = ((state_q == StReq) || (state_q == StWait)) && (cnt_q == TimeoutCnt);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      cnt_q        <= '0;
      params_out   <= '0;
      params_valid <= 1'b0;
      for (int i = 0; i < NUM_WORDS; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      if ((state_q == StWait) && m_readdatavalid && !timed_out) begin
        shadow_q[idx_q] <= m_readdata;
      end
      if (state_q == StCommit) begin
        for (int i = 0; i < NUM_WORDS; i++) begin
          params_out[32*i +: 32] <= shadow_q[i];
        end
        params_valid <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StReq;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      StReq: begin
        if (timed_out) begin
          state_d = StIdle;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (!m_waitrequest) begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (timed_out) begin
          state_d = StIdle;
          idx_d   = '0;
        end else if (m_readdatavalid) begin
          if (idx_q == LastIdx) begin
            state_d = StCommit;
          end else begin
            state_d = StReq;
            idx_d   = idx_q + 1'b1;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StCommit: begin
        state_d = StIdle;
        idx_d   = '0;
      end
      default: begin
        state_d = StIdle;
        idx_d   = '0;
      end
    endcase
  end

  always_comb begin
    busy      = (state_q != StIdle);
    done      = (state_q == StCommit);
    error     = timed_out;
    m_read    = (state_q == StReq) && !timed_out;
    m_address = BASE_ADDR + (32'(idx_q) * ADDR_STRIDE);
  end

endmodule

// File: tb/tb_camera_param_fetch_master.sv
// Bench for camera_param_fetch_master: table of fetch scenarios against a PIO responder model,
// plus hand-written reset, stray-data and address-wrap sequences.
module tb_camera_param_fetch_master;

  localparam int unsigned NW = 6;
  localparam int unsigned TO = 255;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic busy, done, error, m_read, params_valid;
  logic m_waitrequest = 1'b0;
  logic m_readdatavalid = 1'b0;
  logic [31:0] m_readdata = 32'h0;
  logic [31:0] m_address;
  logic [32*NW-1:0] params_out;

  // Second instance for the address wrap case.
  logic start2 = 1'b0;
  logic wr2 = 1'b0;
  logic rdv2 = 1'b0;
  logic [31:0] rd2 = 32'h0;
  logic busy2, done2, error2, m_read2, params_valid2;
  logic [31:0] m_address2;
  logic [63:0] params_out2;

  always #5 clk = ~clk;

  camera_param_fetch_master #(
    .NUM_WORDS(NW), .BASE_ADDR(32'h0), .ADDR_STRIDE(16), .TIMEOUT(TO)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done), .error(error),
    .m_address(m_address), .m_read(m_read), .m_waitrequest(m_waitrequest),
    .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
    .params_out(params_out), .params_valid(params_valid)
  );

  camera_param_fetch_master #(
    .NUM_WORDS(2), .BASE_ADDR(32'hFFFF_FFF0), .ADDR_STRIDE(16), .TIMEOUT(TO)
  ) u_wrap (
    .clk(clk), .reset_n(reset_n), .start(start2), .busy(busy2), .done(done2), .error(error2),
    .m_address(m_address2), .m_read(m_read2), .m_waitrequest(wr2),
    .m_readdata(rd2), .m_readdatavalid(rdv2),
    .params_out(params_out2), .params_valid(params_valid2)
  );

  // Responder knobs (written by the main sequence only).
  logic [31:0] mem [NW];
  int stall_word = -1;
  int stall_cycles = 0;
  int drop_word = -1;
  int stray_req = 0;

  // Scoreboard queues.
  logic [31:0] exp_addr_q [$];
  logic [31:0] acc_q [$];
  logic [31:0] stall_q [$];
  logic [32*NW-1:0] snap_q [$];

  // Responder: decides waitrequest for the current cycle at negedge and returns data
  // one cycle after acceptance.
  int stall_cnt = 0;
  int stray_ack = 0;
  int w;
  logic pend = 1'b0;
  logic [31:0] pend_data = 32'h0;
  always @(negedge clk) begin
    m_readdatavalid = pend;
    m_readdata = pend ? pend_data : 32'h0;
    pend = 1'b0;
    if (stray_ack != stray_req) begin
      m_readdatavalid = 1'b1;
      m_readdata = 32'hDEAD_BEEF;
      stray_ack++;
    end
    if (!m_read) stall_cnt = 0;
    w = int'(m_address[7:4]);
    if (m_read && (w == stall_word) && (stall_cnt < stall_cycles)) begin
      m_waitrequest = 1'b1;
      stall_cnt++;
      stall_q.push_back(m_address);
    end else begin
      m_waitrequest = 1'b0;
      if (m_read) begin
        acc_q.push_back(m_address);
        if ((w != drop_word) && (w < NW)) begin
          pend = 1'b1;
          pend_data = mem[w];
        end
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reads(input string tag, input int n);
    check({tag, "_read_count"}, 256'(acc_q.size()), 256'(n));
    while (acc_q.size() > 0 && exp_addr_q.size() > 0)
      check({tag, "_addr"}, acc_q.pop_front(), exp_addr_q.pop_front());
    acc_q.delete();
    exp_addr_q.delete();
  endtask

  // Pulses start and returns the cycle (start cycle = 0) of done or error, -1 if not seen.
  task automatic do_fetch(input int repulse_at, output int done_c, output int err_c);
    done_c = -1;
    err_c = -1;
    for (int i = 0; i < NW; i++) exp_addr_q.push_back(32'(i * 16));
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      start = (c == repulse_at);
      if (done) done_c = c;
      if (error) err_c = c;
      if (done || error) break;
      step();
    end
    start = 1'b0;
  endtask

  typedef struct {
    logic [31:0] base_word;
    int stall_word;
    int stall_cycles;
    int drop_word;
    int repulse_at;
    int exp_done;
    int exp_err;
  } vec_t;

  localparam int NV = 5;
  vec_t vecs [NV];
  vec_t t;
  logic [32*NW-1:0] snap, exp_snap, prev_snap;
  int done_c, err_c;

  initial begin
    vecs[0] = '{32'h0000_0011, -1, 0, -1, 0, 13, -1};
    vecs[1] = '{32'h1010_0101,  2, 3, -1, 0, 16, -1};
    vecs[2] = '{32'h0BAD_F00D,  0, 1, -1, 5, 14, -1};
    vecs[3] = '{32'h7777_0001,  5, 2, -1, 0, 15, -1};
    vecs[4] = '{32'hCAFE_0000, -1, 0,  4, 0, -1, 9 + TO};
    prev_snap = '0;

    repeat (3) step();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_m_read", m_read, 1'b0);
    check("rst_m_address", m_address, 32'h0);
    check("rst_params_valid", params_valid, 1'b0);
    check("rst_params_out", params_out, '0);
    check("rst_wrap_m_address", m_address2, 32'hFFFF_FFF0);
    reset_n = 1'b1;
    step();

    for (int v = 0; v < NV; v++) begin
      t = vecs[v];
      for (int i = 0; i < NW; i++) mem[i] = t.base_word * 32'(i + 1);
      stall_word = t.stall_word;
      stall_cycles = t.stall_cycles;
      drop_word = t.drop_word;
      for (int i = 0; i < NW; i++) snap[32*i +: 32] = mem[i];
      snap_q.push_back(snap);
      do_fetch(t.repulse_at, done_c, err_c);
      check($sformatf("v%0d_done_cycle", v), 256'(done_c), 256'(t.exp_done));
      check($sformatf("v%0d_error_cycle", v), 256'(err_c), 256'(t.exp_err));
      exp_snap = snap_q.pop_front();
      step();
      if (t.exp_err < 0) begin
        check($sformatf("v%0d_params_out", v), params_out, exp_snap);
        prev_snap = exp_snap;
      end else begin
        check($sformatf("v%0d_params_kept", v), params_out, prev_snap);
      end
      check($sformatf("v%0d_params_valid", v), params_valid, 1'b1);
      check($sformatf("v%0d_busy_after", v), busy, 1'b0);
      repeat (4) step();
      check($sformatf("v%0d_busy_idle", v), busy, 1'b0);
      check_reads($sformatf("v%0d", v), (t.exp_err < 0) ? NW : t.drop_word + 1);
      check($sformatf("v%0d_stall_count", v), 256'(stall_q.size()), 256'(t.stall_cycles));
      while (stall_q.size() > 0)
        check($sformatf("v%0d_stall_addr", v), stall_q.pop_front(), 32'(t.stall_word * 16));
    end
    stall_word = -1;
    stall_cycles = 0;
    drop_word = -1;

    // Stray response while idle must not disturb anything.
    stray_req++;
    done_c = 0;
    repeat (4) begin
      step();
      if (done || busy) done_c++;
    end
    check("stray_no_activity", 256'(done_c), 256'(0));
    check("stray_params_out", params_out, prev_snap);
    check("stray_read_count", 256'(acc_q.size()), 256'(0));

    // Reset asserted during WAIT of word 3.
    for (int i = 0; i < NW; i++) mem[i] = 32'h0300_0003 * 32'(i + 1);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (7) step();
    check("rstmid_in_wait_busy", busy, 1'b1);
    check("rstmid_in_wait_m_address", m_address, 32'h30);
    #1 reset_n = 1'b0;
    #1;
    check("rstmid_m_read", m_read, 1'b0);
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_done_error", {done, error}, 2'b00);
    check("rstmid_params_valid", params_valid, 1'b0);
    check("rstmid_params_out", params_out, '0);
    check("rstmid_m_address", m_address, 32'h0);
    repeat (2) step();
    reset_n = 1'b1;
    check("rstmid_read_count", 256'(acc_q.size()), 256'(4));
    acc_q.delete();
    step();
    for (int i = 0; i < NW; i++) snap[32*i +: 32] = mem[i];
    do_fetch(0, done_c, err_c);
    check("postrst_done_cycle", 256'(done_c), 256'(13));
    step();
    check("postrst_params_out", params_out, snap);
    check("postrst_params_valid", params_valid, 1'b1);
    check_reads("postrst", NW);

    // Address wrap on the second instance.
    step();
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    check("wrap_addr0", m_address2, 32'hFFFF_FFF0);
    check("wrap_read0", m_read2, 1'b1);
    step();
    rdv2 = 1'b1;
    rd2 = 32'hA5A5_0001;
    step();
    rdv2 = 1'b0;
    check("wrap_addr1", m_address2, 32'h0000_0000);
    check("wrap_read1", m_read2, 1'b1);
    step();
    rdv2 = 1'b1;
    rd2 = 32'h5A5A_0002;
    step();
    rdv2 = 1'b0;
    check("wrap_done", done2, 1'b1);
    step();
    check("wrap_params_out", params_out2, {32'h5A5A_0002, 32'hA5A5_0001});
    check("wrap_params_valid", params_valid2, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
